dram_write: RTL and testbench



---
 rtl/dram_write.sv | 167 ++++++++++++++++
 tb/tb_dram_write.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_write.sv
// Write-side timing model of a 16-row DRAM with one open-row buffer.
// Optional per-class accept counters are enabled by defining DRAM_WR_STATS_EN.
module dram_write #(
  parameter int NROWS      = 16,
  parameter int AW         = 4,
  parameter int DW         = 32,
  parameter int T_HIT      = 1,
  parameter int T_EMPTY    = 10,
  parameter int T_CONFLICT = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          input_valid,
  input  logic [AW-1:0] rno,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          output_bit,
  input  logic [AW-1:0] peek_addr,
  output logic [DW-1:0] peek_data
`ifdef DRAM_WR_STATS_EN
  ,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   empty_cnt,
  output logic [15:0]   conflict_cnt
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [7:0]      cnt_r;
  logic [7:0]      lat_s;
  logic [AW-1:0]   rno_lat_r;
  logic [DW-1:0]   wdata_lat_r;
  logic [AW-1:0]   ropen_r;
  logic            ropen_vld_r;
  logic            done_r;
  logic            accept_s;
  logic            commit_s;
  logic            hit_s;
  logic            empty_s;
  logic [DW-1:0]   regfl_r [NROWS];

  function automatic logic in_range(input logic [AW-1:0] a);
    return (32'(a) < NROWS);
  endfunction

  assign accept_s = (state_r == IDLE) && input_valid;
  assign commit_s = (state_r == WAIT) && (cnt_r == 8'd0);
  assign hit_s    = ropen_vld_r && (ropen_r == rno);
  assign empty_s  = !ropen_vld_r;

  // Latency class chosen from the row-buffer state at the moment of accept.
  always_comb begin
    lat_s = 8'(T_CONFLICT);
    if (hit_s) begin
      lat_s = 8'(T_HIT);
    end else if (empty_s) begin
      lat_s = 8'(T_EMPTY);
    end else begin
      lat_s = 8'(T_CONFLICT);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (commit_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode: busy is exactly the WAIT residency.
  always_comb begin
    busy = 1'b0;
    case (state_r)
      IDLE:    busy = 1'b0;
      WAIT:    busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign output_bit = done_r;

  // Request latch, open-row tracking and latency countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= 8'd0;
      rno_lat_r   <= '0;
      wdata_lat_r <= '0;
      ropen_r     <= '0;
      ropen_vld_r <= 1'b0;
      done_r      <= 1'b0;
    end else if (accept_s) begin
      cnt_r       <= lat_s - 8'd1;
      rno_lat_r   <= rno;
      wdata_lat_r <= wdata;
      ropen_r     <= rno;
      ropen_vld_r <= 1'b1;
      done_r      <= 1'b0;
    end else if (commit_s) begin
      done_r      <= 1'b1;
    end else if (state_r == WAIT) begin
      cnt_r       <= cnt_r - 8'd1;
    end
  end

  // Row array; out-of-range rows time normally but never commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NROWS; i++) begin
        regfl_r[i] <= DW'(i);
      end
    end else if (commit_s && in_range(rno_lat_r)) begin
      regfl_r[rno_lat_r] <= wdata_lat_r;
    end
  end

  assign peek_data = in_range(peek_addr) ? regfl_r[peek_addr] : '0;

`ifdef DRAM_WR_STATS_EN
  // Saturating per-class accept counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt      <= 16'd0;
      empty_cnt    <= 16'd0;
      conflict_cnt <= 16'd0;
    end else if (accept_s) begin
      if (hit_s) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else if (empty_s) begin
        if (empty_cnt != 16'hFFFF) empty_cnt <= empty_cnt + 16'd1;
      end else begin
        if (conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dram_write.sv
// Bench for dram_write: remaining-cycles reference model checked every cycle,
// plus directed literal expectations from the write scenarios.
module tb_dram_write;
  localparam int TH = 1;
  localparam int TE = 10;
  localparam int TC = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        input_valid = 1'b0;
  logic [3:0]  rno = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  peek_addr = 4'd0;
  logic        busy;
  logic        output_bit;
  logic [31:0] peek_data;
`ifdef DRAM_WR_STATS_EN
  logic [15:0] hit_cnt, empty_cnt, conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  dram_write dut (
    .clk(clk), .rst(rst), .input_valid(input_valid), .rno(rno), .wdata(wdata),
    .busy(busy), .output_bit(output_bit), .peek_addr(peek_addr), .peek_data(peek_data)
`ifdef DRAM_WR_STATS_EN
    , .hit_cnt(hit_cnt), .empty_cnt(empty_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a pending write is just "cycles remaining"; commit when it hits zero.
  int          m_rem = 0;
  bit          m_done = 1'b0;
  bit          m_vld = 1'b0;
  int          m_open = 0;
  int          m_r = 0;
  logic [31:0] m_d = 32'd0;
  logic [31:0] m_mem [16];
  int          m_hit = 0, m_emp = 0, m_con = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem = 0; m_done = 1'b0; m_vld = 1'b0; m_open = 0;
      m_hit = 0; m_emp = 0; m_con = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 32'(i);
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        if (m_r < 16) m_mem[m_r] = m_d;
        m_done = 1'b1;
      end
    end else if (input_valid) begin
      if (m_vld && m_open == int'(rno)) begin
        m_rem = TH; m_hit = m_hit + 1;
      end else if (!m_vld) begin
        m_rem = TE; m_emp = m_emp + 1;
      end else begin
        m_rem = TC; m_con = m_con + 1;
      end
      m_r = int'(rno); m_d = wdata; m_open = int'(rno); m_vld = 1'b1; m_done = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      check("model_busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
      check("model_done", {31'd0, output_bit}, {31'd0, m_done});
      check("model_peek", peek_data, m_mem[peek_addr]);
`ifdef DRAM_WR_STATS_EN
      check("model_hit_cnt", {16'd0, hit_cnt}, 32'(m_hit));
      check("model_empty_cnt", {16'd0, empty_cnt}, 32'(m_emp));
      check("model_conflict_cnt", {16'd0, conflict_cnt}, 32'(m_con));
`endif
    end
  end

  // Advance one cycle and move the scanning peek address.
  task automatic step();
    @(posedge clk);
    #2;
    peek_addr = peek_addr + 4'd1;
  endtask

  task automatic peek_expect(input string name, input logic [3:0] a, input logic [31:0] exp);
    peek_addr = a;
    #1;
    check(name, peek_data, exp);
  endtask

  task automatic start_write(input logic [3:0] r, input logic [31:0] d);
    input_valid = 1'b1; rno = r; wdata = d;
    step();
    input_valid = 1'b0;
    rno = 4'($urandom);
    wdata = $urandom;
  endtask

  // Counts cycles from accept until output_bit rises; optional ignored request at cycle glitch.
  task automatic wait_done(input int glitch, output int n);
    n = 0;
    while (output_bit !== 1'b1 && n < 100) begin
      step();
      n++;
      if (n == glitch) begin
        input_valid = 1'b1; rno = 4'd2; wdata = 32'd99;
      end else begin
        input_valid = 1'b0;
      end
    end
    input_valid = 1'b0;
    if (n >= 100) check("timeout_done", 32'(n), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2; rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  int n;

  initial begin
    #1 rst = 1'b1;
    checking = 1'b1;
    step(); step();
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, output_bit}, 32'd0);
    peek_expect("reset_row9", 4'd9, 32'd9);

    // Empty-class write.
    start_write(4'd3, 32'hDEAD_BEEF);
    check("empty_busy_after_accept", {31'd0, busy}, 32'd1);
    peek_expect("empty_row3_before_commit", 4'd3, 32'd3);
    wait_done(-1, n);
    check("empty_latency", 32'(n), 32'd10);
    peek_expect("empty_row3_after", 4'd3, 32'hDEAD_BEEF);
    check("empty_done_level", {31'd0, output_bit}, 32'd1);
    step(); step();
    check("done_stays_high", {31'd0, output_bit}, 32'd1);

    // Row hit.
    start_write(4'd3, 32'h0000_1234);
    check("hit_done_cleared", {31'd0, output_bit}, 32'd0);
    wait_done(-1, n);
    check("hit_latency", 32'(n), 32'd1);
    peek_expect("hit_row3", 4'd3, 32'h0000_1234);

    // Conflict with an ignored request in the middle.
    start_write(4'd7, 32'h0000_A5A5);
    wait_done(5, n);
    check("conflict_latency", 32'(n), 32'd20);
    peek_expect("conflict_row7", 4'd7, 32'h0000_A5A5);
    peek_expect("conflict_row3_kept", 4'd3, 32'h0000_1234);
    peek_expect("ignored_row2", 4'd2, 32'd2);

    start_write(4'd7, 32'h0000_C0DE);
    wait_done(-1, n);
    check("follow_hit_latency", 32'(n), 32'd1);
    peek_expect("follow_hit_row7", 4'd7, 32'h0000_C0DE);

    start_write(4'd3, 32'h0000_0BAD);
    wait_done(-1, n);
    check("conflict2_latency", 32'(n), 32'd20);
    peek_expect("conflict2_row3", 4'd3, 32'h0000_0BAD);
`ifdef DRAM_WR_STATS_EN
    check("stats_empty", {16'd0, empty_cnt}, 32'd1);
    check("stats_hit", {16'd0, hit_cnt}, 32'd2);
    check("stats_conflict", {16'd0, conflict_cnt}, 32'd2);
`endif

    // Reset in the middle of an empty-class write.
    do_reset();
    start_write(4'd5, 32'd77);
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, output_bit}, 32'd0);
    peek_expect("abort_row5", 4'd5, 32'd5);
    peek_expect("abort_row3_reimaged", 4'd3, 32'd3);
    step();
    rst = 1'b0;
    start_write(4'd5, 32'd78);
    wait_done(-1, n);
    check("after_abort_empty_latency", 32'(n), 32'd10);
    peek_expect("after_abort_row5", 4'd5, 32'd78);

    step(); step();
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
